// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the 16-bit RISC processor.
//
// Receives a host byte stream over a valid/ready handshake, assembles 16-bit words and writes
// them into the shared memory, holding the CPU in reset until a checksum-verified frame has
// been fully loaded.
//
// Frame (multi-byte fields high byte first):
//   count[15:0] | N x word[15:0] | checksum byte (XOR of every preceding frame byte)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a load (sampled only in IDLE, DONE, ERROR)
//   rx_data    in   host byte
//   rx_valid   in   rx_data is valid
//   rx_ready   out  loader can accept a byte
//   mem_adr    out  write address, BASE_ADR + idx (mod 2^16)
//   mem_wdata  out  assembled word
//   mem_we     out  memory write enable, one cycle per word
//   cpu_hold   out  holds the CPU in reset and gives the loader the memory port
//   busy       out  load in progress
//   done       out  last load succeeded
//   err        out  last load failed
//   status     out  LED pattern {cpu_hold, err, done, 1'b0, state[3:0]}
//
// All outputs are Moore outputs decoded straight from the state and datapath registers.

module prog_loader #(
  parameter logic [15:0] BASE_ADR  = 16'h0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] mem_adr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  status
);

  // Encodings are visible on the status LEDs, so they are fixed explicitly.
  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StCntHi = 4'd1,
    StCntLo = 4'd2,
    StDatHi = 4'd3,
    StDatLo = 4'd4,
    StWrite = 4'd5,
    StChk   = 4'd6,
    StDone  = 4'd7,
    StError = 4'd8
  } state_e;

  // One bit wider than the count so a limit of 65536 still compares correctly.
  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] idx_q;
  logic [15:0] word_q;
  logic [7:0]  chk_q;

  logic        rx_fire;
  logic [15:0] count_full;
  logic        last_word;

  assign rx_fire    = rx_valid & rx_ready;
  // Complete count as it will be once the low byte in CNT_LO is taken.
  assign count_full = {count_q[15:8], rx_data};
  // count is at least 1 whenever WRITE is reached, so count-1 cannot wrap.
  assign last_word  = (idx_q == (count_q - 16'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      chk_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_q <= StCntHi;
            count_q <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
          end
        end

        StCntHi: begin
          if (rx_fire) begin
            count_q[15:8] <= rx_data;
            chk_q         <= chk_q ^ rx_data;
            state_q       <= StCntLo;
          end
        end

        StCntLo: begin
          if (rx_fire) begin
            count_q[7:0] <= rx_data;
            chk_q        <= chk_q ^ rx_data;
            if ({1'b0, count_full} > MaxWords) begin
              state_q <= StError;
            end else if (count_full == 16'd0) begin
              state_q <= StChk;
            end else begin
              state_q <= StDatHi;
            end
          end
        end

        StDatHi: begin
          if (rx_fire) begin
            word_q[15:8] <= rx_data;
            chk_q        <= chk_q ^ rx_data;
            state_q      <= StDatLo;
          end
        end

        StDatLo: begin
          if (rx_fire) begin
            word_q[7:0] <= rx_data;
            chk_q       <= chk_q ^ rx_data;
            state_q     <= StWrite;
          end
        end

        // Single write cycle; rx_ready is low here so the host stalls for it.
        StWrite: begin
          idx_q   <= idx_q + 16'd1;
          state_q <= last_word ? StChk : StDatHi;
        end

        StChk: begin
          if (rx_fire) begin
            state_q <= (rx_data == chk_q) ? StDone : StError;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_hold  = 1'b1;
    mem_adr   = BASE_ADR + idx_q;
    mem_wdata = word_q;

    unique case (state_q)
      StCntHi, StCntLo, StDatHi, StDatLo, StChk: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      StWrite: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      StDone: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      StError: begin
        err = 1'b1;
      end
      default: ;
    endcase

    status = {cpu_hold, err, done, 1'b0, state_q};
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed frames from the test plan plus randomized frames.
// Expected writes are queued by the stimulus and consumed by an independent write monitor;
// frame outcome comes from a byte-level model of the frame rules.

module tb_prog_loader;

  localparam logic [15:0] Base = 16'h0000;
  localparam int          MaxW = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] mem_adr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  status;

  prog_loader #(
    .BASE_ADR (Base),
    .MAX_WORDS(MaxW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_adr  (mem_adr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .status   (status)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  bit abort = 1'b0;

  logic [15:0] exp_adr_q[$];
  logic [15:0] exp_dat_q[$];
  logic [15:0] mem_act[int];
  logic [15:0] words[$];
  logic [15:0] mon_a, mon_d;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      we_cnt++;
      mem_act[int'(mem_adr)] = mem_wdata;
      if (exp_adr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got adr %h data %h, expected no write", mem_adr,
                 mem_wdata);
      end else begin
        mon_a = exp_adr_q.pop_front();
        mon_d = exp_dat_q.pop_front();
        check("write_adr", mem_adr, mon_a);
        check("write_data", mem_wdata, mon_d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Present one byte after `gap` idle cycles; returns at the negedge after acceptance.
  // With `pulse`, start is raised for one cycle inside the gap.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int n;
    if (abort) return;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (pulse && i == 2) start = 1'b1;
      if (pulse && i == 3) start = 1'b0;
      @(negedge clk);
    end
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL rx_timeout: rx_ready stayed 0 for byte %h, expected 1", b);
      abort    = 1'b1;
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 16'(busy), 16'd1);
    check("start_ready", 16'(rx_ready), 16'd1);
    check("start_hold", 16'(cpu_hold), 16'd1);
    check("start_done_clr", 16'(done), 16'd0);
    check("start_err_clr", 16'(err), 16'd0);
  endtask

  // Runs one frame from `words`; corrupt is XORed into the checksum byte.
  task automatic run_frame(input logic [15:0] cnt, input logic [7:0] corrupt,
                           input int gapmax, input bit pulse);
    logic [7:0] chk;
    bit ok;
    int g;
    abort  = 1'b0;
    we_cnt = 0;
    chk    = 8'h00;
    start_load();
    g = pulse ? 5 : int'($urandom_range(0, gapmax));
    send_byte(cnt[15:8], g, 1'b0);
    g = pulse ? 5 : int'($urandom_range(0, gapmax));
    send_byte(cnt[7:0], g, 1'b0);
    chk = chk ^ cnt[15:8] ^ cnt[7:0];
    if (int'(cnt) > MaxW) begin
      check("oversize_err", 16'(err), 16'd1);
      check("oversize_ready", 16'(rx_ready), 16'd0);
      check("oversize_status", 16'(status), 16'h00C8);
      check("oversize_writes", 16'(we_cnt), 16'd0);
      return;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      exp_adr_q.push_back(Base + 16'(i));
      exp_dat_q.push_back(words[i]);
      g = pulse ? 5 : int'($urandom_range(0, gapmax));
      send_byte(words[i][15:8], g, pulse);
      g = pulse ? 5 : int'($urandom_range(0, gapmax));
      send_byte(words[i][7:0], g, 1'b0);
      chk = chk ^ words[i][15:8] ^ words[i][7:0];
      if (!abort) begin
        check("we_after_lo", 16'(mem_we), 16'd1);
        check("ready_in_write", 16'(rx_ready), 16'd0);
      end
    end
    g = pulse ? 5 : int'($urandom_range(0, gapmax));
    send_byte(chk ^ corrupt, g, 1'b0);
    ok = (corrupt == 8'h00);
    check("end_done", 16'(done), ok ? 16'd1 : 16'd0);
    check("end_err", 16'(err), ok ? 16'd0 : 16'd1);
    check("end_hold", 16'(cpu_hold), ok ? 16'd0 : 16'd1);
    check("end_busy", 16'(busy), 16'd0);
    check("end_status", 16'(status), ok ? 16'h0027 : 16'h00C8);
    check("end_we_count", 16'(we_cnt), cnt);
    check("end_queue_empty", 16'(exp_adr_q.size()), 16'd0);
    exp_adr_q.delete();
    exp_dat_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_status"}, 16'(status), 16'h0080);
    check({tag, "_ready"}, 16'(rx_ready), 16'd0);
    check({tag, "_we"}, 16'(mem_we), 16'd0);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    check({tag, "_done"}, 16'(done), 16'd0);
    check({tag, "_err"}, 16'(err), 16'd0);
    check({tag, "_hold"}, 16'(cpu_hold), 16'd1);
    check({tag, "_adr"}, mem_adr, Base);
    check({tag, "_wdata"}, mem_wdata, 16'h0000);
  endtask

  initial begin
    logic [15:0] cnt;
    logic [7:0]  cm;

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    // Three-word load.
    words = '{16'h1234, 16'hABCD, 16'h0001};
    run_frame(16'd3, 8'h00, 0, 1'b0);
    check("three_m0", mem_act[0], 16'h1234);
    check("three_m1", mem_act[1], 16'hABCD);
    check("three_m2", mem_act[2], 16'h0001);

    // Bad checksum: final byte 43 instead of 42.
    run_frame(16'd3, 8'h01, 0, 1'b0);

    // Reset asserted in DAT_LO of the second word.
    abort = 1'b0;
    start_load();
    exp_adr_q.push_back(Base);
    exp_dat_q.push_back(16'h1234);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    check("rst_queue_empty", 16'(exp_adr_q.size()), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // Empty frame.
    words.delete();
    run_frame(16'd0, 8'h00, 0, 1'b0);

    // Oversize count 0x0101.
    run_frame(16'h0101, 8'h00, 0, 1'b0);

    // Stalls between every byte with start pulsed in DAT_HI.
    mem_act.delete();
    words = '{16'h1234, 16'hABCD, 16'h0001};
    run_frame(16'd3, 8'h00, 0, 1'b1);
    check("stall_m0", mem_act[0], 16'h1234);
    check("stall_m1", mem_act[1], 16'hABCD);
    check("stall_m2", mem_act[2], 16'h0001);

    // Largest accepted count, reloaded straight from DONE.
    words.delete();
    for (int i = 0; i < MaxW; i++) words.push_back(16'($urandom));
    run_frame(16'(MaxW), 8'h00, 0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 9) == 0) cnt = 16'($urandom_range(MaxW + 1, 65535));
      else cnt = 16'($urandom_range(0, 5));
      words.delete();
      for (int i = 0; i < 6; i++) words.push_back(16'($urandom));
      cm = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run_frame(cnt, cm, 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
